// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse-train transmitter.
//
// A one-cycle start request samples the width/gap/count configuration into
// shadow registers and emits a train of clock-aligned pulses on pls_out.
// The bench-side sequencer sees busy while the train runs and a one-cycle done
// strobe when it completes. abort ends a train early with no done strobe.
//
// Optional feature: define PTG_TOTAL_CNT_EN to add tot_cnt, a saturating
// 16-bit count of pulses emitted since reset (unaffected by abort).
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle request; samples config and begins a train
//   abort      in   terminates a train in progress
//   pls_width  in   high time per pulse in cycles (0 treated as 1)
//   pls_gap    in   low time between pulses in cycles (0 treated as 1)
//   pls_count  in   number of pulses in the train
//   pls_out    out  output pulse, decoded from registered state
//   busy       out  train in progress (HIGH or GAP)
//   done       out  one-cycle completion strobe
//   tot_cnt    out  running pulse total (PTG_TOTAL_CNT_EN only)

module pulse_train_gen #(
    parameter int unsigned WID_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WID_W-1:0] pls_width,
    input  logic [WID_W-1:0] pls_gap,
    input  logic [CNT_W-1:0] pls_count,
    output logic             pls_out,
    output logic             busy,
`ifdef PTG_TOTAL_CNT_EN
    output logic             done,
    output logic [15:0]      tot_cnt
`else
    output logic             done
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [WID_W-1:0] WidOne = {{(WID_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WID_W-1:0] width_q, width_d;
    logic [WID_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WID_W-1:0] tmr_q, tmr_d;

    // Timer load value: the phase lasts (load + 1) cycles, so a field of 0 or 1
    // both give a single cycle and 255 gives exactly 255 cycles without wrap.
    function automatic logic [WID_W-1:0] tmr_load(input logic [WID_W-1:0] v);
        return (v == '0) ? '0 : (v - WidOne);
    endfunction

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        gap_d   = gap_q;
        rem_d   = rem_q;
        tmr_d   = tmr_q;

        case (state_q)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    width_d = pls_width;
                    gap_d   = pls_gap;
                    rem_d   = pls_count;
                    if (pls_count == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = HIGH;
                        tmr_d   = tmr_load(pls_width);
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    rem_d = rem_q - CntOne;
                    if (rem_q == CntOne) begin
                        // last pulse: no trailing gap
                        state_d = FIN;
                    end else begin
                        state_d = GAP;
                        tmr_d   = tmr_load(gap_q);
                    end
                end else begin
                    tmr_d = tmr_q - WidOne;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    state_d = HIGH;
                    tmr_d   = tmr_load(width_q);
                end else begin
                    tmr_d = tmr_q - WidOne;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            width_q <= '0;
            gap_q   <= '0;
            rem_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
        end
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // and pls_out falls as soon as reset is asserted.
    assign pls_out = (state_q == HIGH);
    assign busy    = (state_q == HIGH) || (state_q == GAP);
    assign done    = (state_q == FIN);

`ifdef PTG_TOTAL_CNT_EN
    logic [15:0] tot_q, tot_d;

    always_comb begin
        tot_d = tot_q;
        // count on entry to HIGH, holding at all-ones
        if ((state_d == HIGH) && (state_q != HIGH) && (tot_q != 16'hFFFF)) begin
            tot_d = tot_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tot_q <= '0;
        end else begin
            tot_q <= tot_d;
        end
    end

    assign tot_cnt = tot_q;
`endif

endmodule
